// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM bus arbiter.
package sram_arb_pkg;

  // Requester identity, also the payload of the in-order ID FIFO
  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_t;

  localparam int SIZE_W  = 2;
  localparam int WSTRB_W = 4;

endpackage

// File: rtl/sram_arb_idfifo.sv
// In-order FIFO of requester IDs; one entry per accepted, not yet returned request.
module sram_arb_idfifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  src_t din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output src_t head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  src_t            mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  // Guard against overflow/underflow so a stray pop can never corrupt the count
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-to-one SRAM-like bus arbiter (fetch port vs load/store port).
// Grant is held from first presentation until addr_ok; returns are routed
// back in order through an ID FIFO.
// Optional feature: define SRAM_ARB_RR_EN for round-robin arbitration;
// otherwise the data port has fixed priority over the inst port.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic               clk,
  input  logic               resetn,
  // requester 0: instruction fetch
  input  logic               inst_req,
  input  logic               inst_wr,
  input  logic [SIZE_W-1:0]  inst_size,
  input  logic [WSTRB_W-1:0] inst_wstrb,
  input  logic [AW-1:0]      inst_addr,
  input  logic [DW-1:0]      inst_wdata,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,
  output logic [DW-1:0]      inst_rdata,
  // requester 1: load/store
  input  logic               data_req,
  input  logic               data_wr,
  input  logic [SIZE_W-1:0]  data_size,
  input  logic [WSTRB_W-1:0] data_wstrb,
  input  logic [AW-1:0]      data_addr,
  input  logic [DW-1:0]      data_wdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,
  output logic [DW-1:0]      data_rdata,
  // downstream
  output logic               m_req,
  output logic               m_wr,
  output logic [SIZE_W-1:0]  m_size,
  output logic [WSTRB_W-1:0] m_wstrb,
  output logic [AW-1:0]      m_addr,
  output logic [DW-1:0]      m_wdata,
  input  logic               m_addr_ok,
  input  logic               m_data_ok,
  input  logic [DW-1:0]      m_rdata
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } st_t;

  st_t  state_q, state_d;
  src_t lock_src_q, lock_src_d;
  src_t pref, gnt;
  logic gnt_req, accept, ret_vld;
  logic fifo_full, fifo_empty;
  src_t fifo_head;

`ifdef SRAM_ARB_RR_EN
  src_t last_src_q;

  // Remember the winner of the most recent accept for round-robin
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     last_src_q <= SRC_INST;
    else if (accept) last_src_q <= gnt;
  end

  assign pref = (last_src_q == SRC_DATA) ? SRC_INST : SRC_DATA;
`else
  assign pref = SRC_DATA;
`endif

  // Grant: held source while locked, otherwise decided from live requests
  always_comb begin
    gnt = SRC_INST;
    if (state_q == ST_LOCKED)      gnt = lock_src_q;
    else if (inst_req && data_req) gnt = pref;
    else if (data_req)             gnt = SRC_DATA;
  end

  assign gnt_req = (gnt == SRC_DATA) ? data_req : inst_req;
  // A full FIFO blocks the request even if a pop is happening this cycle
  assign m_req   = gnt_req && !fifo_full;
  assign accept  = m_req && m_addr_ok;

  assign m_wr    = (gnt == SRC_DATA) ? data_wr    : inst_wr;
  assign m_size  = (gnt == SRC_DATA) ? data_size  : inst_size;
  assign m_wstrb = (gnt == SRC_DATA) ? data_wstrb : inst_wstrb;
  assign m_addr  = (gnt == SRC_DATA) ? data_addr  : inst_addr;
  assign m_wdata = (gnt == SRC_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = accept && (gnt == SRC_INST);
  assign data_addr_ok = accept && (gnt == SRC_DATA);

  // Lock state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      lock_src_q <= SRC_INST;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
    end
  end

  // Lock next-state: latch the grant when the bus stalls the address phase
  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    case (state_q)
      ST_IDLE: begin
        if (m_req && !m_addr_ok) begin
          state_d    = ST_LOCKED;
          lock_src_d = gnt;
        end
      end
      ST_LOCKED: begin
        if (m_addr_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beats arriving with nothing outstanding are dropped
  assign ret_vld      = m_data_ok && !fifo_empty;
  assign inst_data_ok = ret_vld && (fifo_head == SRC_INST);
  assign data_data_ok = ret_vld && (fifo_head == SRC_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  sram_arb_idfifo #(
    .DEPTH (OUTSTANDING)
  ) u_idfifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (accept),
    .din_i   (gnt),
    .pop_i   (ret_vld),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule
